// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
//   cond_t      - 3-bit branch condition code as carried on cond_i
//   FLAG_*      - bit positions inside the 3-bit flags vector {V, N, Z}
//   pc_state_t  - PC unit state (RUN / HALTED)
package pc_pkg;

    typedef enum logic [2:0] {
        COND_NE     = 3'b000,
        COND_EQ     = 3'b001,
        COND_GT     = 3'b010,
        COND_LT     = 3'b011,
        COND_GE     = 3'b100,
        COND_LE     = 3'b101,
        COND_OV     = 3'b110,
        COND_UNCOND = 3'b111
    } cond_t;

    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_cond_eval.sv
// pc_cond_eval: combinational branch-condition evaluator.
//   cond      in  cond_t  condition code
//   flags     in  3       {V, N, Z}
//   cond_true out 1       condition holds for the given flags
module pc_cond_eval
    import pc_pkg::*;
(
    input  cond_t      cond,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic v, n, z;

    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_NE:     cond_true = ~z;
            COND_EQ:     cond_true = z;
            COND_GT:     cond_true = ~z & ~n;
            COND_LT:     cond_true = n;
            COND_GE:     cond_true = z | ~n;
            COND_LE:     cond_true = z | n;
            COND_OV:     cond_true = v;
            COND_UNCOND: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural fetch PC with branch redirect, stall, halt and a
// saturating taken-branch counter.
//   clk, rst_n      clock; synchronous active-low reset
//   stall_i         hold PC this cycle
//   halt_i          HLT decoded in fetch; freezes the unit until reset
//   br_valid_i      a branch resolves this cycle
//   br_type_i       0 = PC-relative B, 1 = register BR
//   cond_i, flags_i condition code and {V,N,Z}
//   off_i           signed B offset in instruction units
//   br_base_i       PC+INC of the branch instruction
//   rs_i            BR target
//   pc_o            registered fetch PC; pc_plus_o = pc_o+INC
//   taken_o         combinational taken indication
//   flush_o         one-cycle pulse after each taken branch
//   halted_o        unit is in HALTED
//   br_cnt_o        saturating taken-branch count
module pc_unit
    import pc_pkg::*;
#(
    parameter int          PC_W     = 16,
    parameter int          OFF_W    = 9,
    parameter int unsigned INC      = 2,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             br_valid_i,
    input  logic             br_type_i,
    input  logic [2:0]       cond_i,
    input  logic [2:0]       flags_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [PC_W-1:0]  br_base_i,
    input  logic [PC_W-1:0]  rs_i,
    output logic [PC_W-1:0]  pc_o,
    output logic [PC_W-1:0]  pc_plus_o,
    output logic             taken_o,
    output logic             flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] br_cnt_o
);

    localparam logic [PC_W-1:0]  PC_INC   = PC_W'(INC);
    localparam logic [PC_W-1:0]  PC_RST   = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    pc_state_t        state;
    logic             cond_true;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  b_target;
    logic [PC_W-1:0]  target;

    pc_cond_eval u_cond (
        .cond      (cond_t'(cond_i)),
        .flags     (flags_i),
        .cond_true (cond_true)
    );

    // Offset is in instruction units (2 bytes); sign-extend to PC width,
    // then scale. All sums wrap mod 2^PC_W.
    assign off_ext   = PC_W'($signed(off_i));
    assign b_target  = br_base_i + (off_ext << 1);
    assign target    = br_type_i ? rs_i : b_target;

    assign pc_plus_o = pc_o + PC_INC;
    assign taken_o   = br_valid_i & cond_true & (state == ST_RUN);
    assign halted_o  = (state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_o     <= PC_RST;
            flush_o  <= 1'b0;
            br_cnt_o <= '0;
            state    <= ST_RUN;
        end else begin
            // taken_o is already gated by RUN, so no flush can leave HALTED.
            flush_o <= taken_o;
            case (state)
                ST_RUN: begin
                    // Taken branch is older than the stall/halt in fetch,
                    // so it wins; a halt alongside it is wrong-path.
                    if (taken_o) begin
                        pc_o <= target;
                        if (br_cnt_o != CNT_MAX)
                            br_cnt_o <= br_cnt_o + 1'b1;
                    end else if (stall_i) begin
                        pc_o <= pc_o;
                    end else if (halt_i) begin
                        state <= ST_HALTED;
                    end else begin
                        pc_o <= pc_plus_o;
                    end
                end
                ST_HALTED: begin
                    // Only reset leaves HALTED.
                    state <= ST_HALTED;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int PC_W  = 16;
    localparam int OFF_W = 9;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall_i, halt_i, br_valid_i, br_type_i;
    logic [2:0]       cond_i, flags_i;
    logic [OFF_W-1:0] off_i;
    logic [PC_W-1:0]  br_base_i, rs_i;
    logic [PC_W-1:0]  pc_o, pc_plus_o;
    logic             taken_o, flush_o, halted_o;
    logic [CNT_W-1:0] br_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_W(PC_W), .OFF_W(OFF_W), .INC(2), .RESET_PC(0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .halt_i(halt_i),
        .br_valid_i(br_valid_i), .br_type_i(br_type_i), .cond_i(cond_i),
        .flags_i(flags_i), .off_i(off_i), .br_base_i(br_base_i), .rs_i(rs_i),
        .pc_o(pc_o), .pc_plus_o(pc_plus_o), .taken_o(taken_o),
        .flush_o(flush_o), .halted_o(halted_o), .br_cnt_o(br_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; halt_i = 0; br_valid_i = 0; br_type_i = 0;
        cond_i = 3'd0; flags_i = 3'd0; off_i = '0; br_base_i = '0; rs_i = '0;
    endtask

    // Reference condition table, flags = {V, N, Z}
    function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] f);
        logic v, n, z;
        v = f[2]; n = f[1]; z = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic do_br(input logic [PC_W-1:0] tgt);
        br_valid_i = 1; br_type_i = 1; cond_i = 3'd7; rs_i = tgt;
        step();
        br_valid_i = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #1;
        step();
        check("rst_pc", pc_o, 32'h0);
        check("rst_flush", flush_o, 0);
        check("rst_halted", halted_o, 0);
        check("rst_cnt", br_cnt_o, 0);
        check("rst_taken", taken_o, 0);
        check("rst_pc_plus", pc_plus_o, 32'h2);
        rst_n = 1;

        // Free run
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("run_pc%0d", i), pc_o, 32'(2 * i));
            check($sformatf("run_flush%0d", i), flush_o, 0);
        end

        // Taken B: 0x000E + (-3 << 1) = 0x0008
        br_valid_i = 1; br_type_i = 0; cond_i = 3'd0; flags_i = 3'b000;
        off_i = 9'h1FD; br_base_i = 16'h000E;
        #1 check("b_taken", taken_o, 1);
        step();
        check("b_pc", pc_o, 32'h0008);
        check("b_flush", flush_o, 1);
        check("b_cnt", br_cnt_o, 1);
        idle();
        step();
        check("b_pc_next", pc_o, 32'h000A);
        check("b_flush_clr", flush_o, 0);
        step(); step(); step();
        check("b2_pc_pre", pc_o, 32'h0010);

        // Not-taken B (Z=1 with NE)
        br_valid_i = 1; br_type_i = 0; cond_i = 3'd0; flags_i = 3'b001;
        off_i = 9'h1FD; br_base_i = 16'h000E;
        #1 check("nt_taken", taken_o, 0);
        step();
        check("nt_pc", pc_o, 32'h0012);
        check("nt_flush", flush_o, 0);
        check("nt_cnt", br_cnt_o, 1);

        // BR under stall
        idle();
        stall_i = 1; br_valid_i = 1; br_type_i = 1; rs_i = 16'h1234; cond_i = 3'd7;
        step();
        check("br_pc", pc_o, 32'h1234);
        check("br_flush", flush_o, 1);
        check("br_cnt", br_cnt_o, 2);
        br_valid_i = 0;
        step();
        check("stall_pc1", pc_o, 32'h1234);
        check("stall_flush", flush_o, 0);
        step();
        check("stall_pc2", pc_o, 32'h1234);
        stall_i = 0;
        step();
        check("stall_resume", pc_o, 32'h1236);

        // Condition sweep (combinational only)
        br_valid_i = 1;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                cond_i = 3'(c); flags_i = 3'(f);
                #1 check($sformatf("cond%0d_f%0d", c, f), taken_o, cond_ref(3'(c), 3'(f)));
            end
        end
        cond_i = 3'd5; flags_i = 3'b010;
        #1 check("le_n1z0", taken_o, 1);
        cond_i = 3'd4; flags_i = 3'b010;
        #1 check("ge_n1", taken_o, 0);
        idle();
        #1;

        // Halt
        do_br(16'h0040);
        check("h_pc_pre", pc_o, 32'h0040);
        check("cnt_sat_a", br_cnt_o, 3);
        halt_i = 1;
        step();
        halt_i = 0;
        check("h_halted", halted_o, 1);
        check("h_pc", pc_o, 32'h0040);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                br_valid_i = 1; br_type_i = 0; cond_i = 3'd7;
                br_base_i = 16'h0100; off_i = 9'h005; stall_i = 1; halt_i = 1;
                #1 check("h_taken_blocked", taken_o, 0);
            end
            step();
            idle();
            check($sformatf("h_hold%0d", i), pc_o, 32'h0040);
            check($sformatf("h_halted%0d", i), halted_o, 1);
            check($sformatf("h_flush%0d", i), flush_o, 0);
        end

        // Reset mid-halt with a branch present
        rst_n = 0; br_valid_i = 1; br_type_i = 1; cond_i = 3'd7; rs_i = 16'h5555;
        step();
        check("r_pc", pc_o, 32'h0);
        check("r_halted", halted_o, 0);
        check("r_cnt", br_cnt_o, 0);
        check("r_flush", flush_o, 0);
        rst_n = 1; idle();

        // Halt together with a taken branch: branch wins
        halt_i = 1; br_valid_i = 1; br_type_i = 1; cond_i = 3'd7; rs_i = 16'h0100;
        step();
        idle();
        check("hb_pc", pc_o, 32'h0100);
        check("hb_halted", halted_o, 0);
        check("hb_flush", flush_o, 1);
        step();
        check("hb_pc_next", pc_o, 32'h0102);
        check("hb_halted2", halted_o, 0);

        // B target wrap: 0x0000 + (-1 << 1) = 0xFFFE; then sequential wrap
        br_valid_i = 1; br_type_i = 0; cond_i = 3'd7; br_base_i = 16'h0000; off_i = 9'h1FF;
        step();
        idle();
        check("wrap_b", pc_o, 32'hFFFE);
        check("wrap_cnt", br_cnt_o, 2);
        step();
        check("wrap_seq", pc_o, 32'h0000);

        // Back-to-back taken branches: flush each cycle, counter saturates
        br_valid_i = 1; br_type_i = 1; cond_i = 3'd7; rs_i = 16'h0200;
        step();
        check("bb_flush1", flush_o, 1);
        check("sat_cnt3", br_cnt_o, 3);
        rs_i = 16'h0300;
        step();
        idle();
        check("bb_flush2", flush_o, 1);
        check("bb_pc", pc_o, 32'h0300);
        check("sat_cnt4", br_cnt_o, 3);
        step();
        check("bb_flush_end", flush_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined CPU. It holds the architectural fetch PC, advances it each cycle, and resolves conditional PC-relative (B) and register-indirect (BR) branches sent back from decode/execute. It also handles stall, halt and redirect flushing, and counts taken branches. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
Parameters:
- PC_W, 16, PC and address width
- OFF_W, 9, signed B-offset width, in instruction units
- INC, 2, sequential increment in bytes
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, taken-branch counter width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- stall_i  in  1  hold PC (fetch back-pressure / hazard)
- halt_i  in  1  HLT decoded in fetch
- br_valid_i  in  1  branch instruction resolving this cycle
- br_type_i  in  1  0 = B (PC-relative), 1 = BR (register)
- cond_i  in  3  condition code
- flags_i  in  3  [2]=V, [1]=N, [0]=Z
- off_i  in  OFF_W  signed B offset
- br_base_i  in  PC_W  PC+INC of the branch instruction
- rs_i  in  PC_W  BR target register value
- pc_o  out  PC_W  current fetch PC (registered)
- pc_plus_o  out  PC_W  pc_o+INC, combinational
- taken_o  out  1  combinational: the branch resolving this cycle is taken
- flush_o  out  1  registered: younger fetch/decode contents invalid
- halted_o  out  1  registered: unit is in HALTED
- br_cnt_o  out  CNT_W  saturating count of taken branches

## Operation
- Conditions:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | ~N
  - 101 LE: Z | N
  - 110 OV: V
  - 111 always
- Both B and BR use the condition evaluation.
- taken_o = br_valid_i & cond_true & state==RUN.
- B target = br_base_i + (sign_extend(off_i) << 1), computed mod 2^PC_W. BR target = rs_i, used unmodified.
- Sequential PC arithmetic wraps mod 2^PC_W: 0xFFFE+2 = 0x0000. There is no overflow indication.
- States:
  - RUN, entered on reset.
  - HALTED, left only by reset.
- Next-PC priority in RUN, highest first:
  1. taken → target
  2. stall_i → hold
  3. halt_i → hold and go to HALTED
  4. otherwise → pc_o+INC
- A taken branch overrides stall and halt, because the branch is older. When a branch and halt_i arrive together, the halt is on the wrong path and is ignored.
- A not-taken branch with br_valid_i has no effect beyond normal priority.
- In HALTED: pc_o frozen, and br_valid_i, stall_i and halt_i are all ignored.
- br_cnt_o increments on each taken branch and saturates at all-ones.

## Timing
- Reset values: pc_o=RESET_PC, flush_o=0, halted_o=0, br_cnt_o=0, state RUN. taken_o=0 follows from the reset state.
- Reset wins over every other input in the same cycle, including mid-halt and with br_valid_i high.
- Redirect latency is 1 cycle. With a taken branch in cycle N, pc_o equals the target in cycle N+1 and flush_o=1 in cycle N+1 only.
- flush_o stays high for exactly one cycle per taken branch. Back-to-back taken branches give back-to-back flush cycles.
- halt_i sampled in cycle N gives halted_o=1 from cycle N+1, with pc_o still equal to the HLT address.
- Stall holds pc_o for as long as it is asserted. Increment resumes on the first edge after stall_i falls.

## Structure
- Package pc_pkg:
  - cond_t enum (NE, EQ, GT, LT, GE, LE, OV, UNCOND)
  - FLAG_V/FLAG_N/FLAG_Z bit-index localparams
  - pc_state_t enum (RUN, HALTED)
- Sub-module pc_cond_eval: combinational cond_t × flags → cond_true. Shared with the verification model.
- Adders are plain behavioural adds of width PC_W.

## Test plan
- Reset then free-run: rst_n=0 one cycle, then 4 idle cycles → pc_o sequence 0x0000, 0x0002, 0x0004, 0x0006, 0x0008. flush_o=0 throughout.
- Taken B: pc_o=0x0010, br_base_i=0x000E, off_i=-3, cond=NE, Z=0 → next pc_o=0x0008, flush_o=1 for one cycle, br_cnt_o=1. Repeat with Z=1 → pc_o=0x0012, no flush.
- BR under stall: stall_i=1, br_type_i=1, rs_i=0x1234, cond=111 → next pc_o=0x1234. Next cycle with stall_i still 1 → pc_o holds 0x1234.
- Condition sweep: every cond_i against all 8 flag values → taken_o matches the condition list in Operation. Include LE with N=1, Z=0 (taken) and GE with N=1 (not taken).
- Halt then reset:
  - halt_i with pc_o=0x0040 → halted_o=1, pc_o stays at 0x0040 for 10 cycles, and a taken B during HALTED is ignored.
  - rst_n=0 → pc_o=0x0000, halted_o=0.
  - halt_i together with a taken branch → branch wins and halted_o stays 0.
- Wrap and saturation:
  - pc_o=0xFFFE idle → 0x0000.
  - With CNT_W=2, four taken branches → br_cnt_o=3.
